// File: rtl/host_wg_issuer_if.sv
// rtl/host_wg_issuer_if.sv - WG descriptor / completion bus between host_wg_issuer and inflight_wg_buffer
// Ports (master = issuer side):
//   host_wg_valid, host_wg_id, host_num_wf, host_wf_size,
//   host_vgpr_size_total, host_vgpr_size_per_wf,
//   host_sgpr_size_total, host_sgpr_size_per_wf,
//   host_lds_size_total, host_gds_size_total        : descriptor, driven by master
//   inflight_wg_buffer_host_rcvd_ack                : descriptor accepted, driven by slave
//   inflight_wg_buffer_host_wf_done(_wg_id)         : WG completion pulse and id, driven by slave
interface host_wg_issuer_if #(
  parameter int WG_ID_WIDTH      = 6,
  parameter int WG_SLOT_ID_WIDTH = 6,
  parameter int VGPR_ID_WIDTH    = 8,
  parameter int SGPR_ID_WIDTH    = 8,
  parameter int LDS_ID_WIDTH     = 8,
  parameter int GDS_ID_WIDTH     = 8
) ();
  logic                        host_wg_valid;
  logic [WG_ID_WIDTH-1:0]      host_wg_id;
  logic [WG_SLOT_ID_WIDTH:0]   host_num_wf;
  logic [5:0]                  host_wf_size;
  logic [VGPR_ID_WIDTH:0]      host_vgpr_size_total;
  logic [VGPR_ID_WIDTH:0]      host_vgpr_size_per_wf;
  logic [SGPR_ID_WIDTH:0]      host_sgpr_size_total;
  logic [SGPR_ID_WIDTH:0]      host_sgpr_size_per_wf;
  logic [LDS_ID_WIDTH:0]       host_lds_size_total;
  logic [GDS_ID_WIDTH:0]       host_gds_size_total;
  logic                        inflight_wg_buffer_host_rcvd_ack;
  logic                        inflight_wg_buffer_host_wf_done;
  logic [WG_ID_WIDTH-1:0]      inflight_wg_buffer_host_wf_done_wg_id;

  modport master (
    output host_wg_valid, host_wg_id, host_num_wf, host_wf_size,
           host_vgpr_size_total, host_vgpr_size_per_wf,
           host_sgpr_size_total, host_sgpr_size_per_wf,
           host_lds_size_total, host_gds_size_total,
    input  inflight_wg_buffer_host_rcvd_ack, inflight_wg_buffer_host_wf_done,
           inflight_wg_buffer_host_wf_done_wg_id
  );

  modport slave (
    input  host_wg_valid, host_wg_id, host_num_wf, host_wf_size,
           host_vgpr_size_total, host_vgpr_size_per_wf,
           host_sgpr_size_total, host_sgpr_size_per_wf,
           host_lds_size_total, host_gds_size_total,
    output inflight_wg_buffer_host_rcvd_ack, inflight_wg_buffer_host_wf_done,
           inflight_wg_buffer_host_wf_done_wg_id
  );
endinterface

// File: rtl/host_wg_issuer.sv
// rtl/host_wg_issuer.sv - issues one WG descriptor per workgroup of a kernel launch and tracks completions
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start, cfg_*             : launch pulse and kernel descriptor (sampled in IDLE only)
//   dis                      : descriptor handshake and completion stream (master side)
//   busy                     : not idle
//   kernel_done, cfg_error   : one-cycle pulses (all WGs complete / launch rejected)
//   done_error               : sticky illegal-completion flag, cleared by accepted start
//   wg_issued_count, wg_done_count : progress counters
module host_wg_issuer #(
  parameter int WG_ID_WIDTH      = 6,
  parameter int WG_SLOT_ID_WIDTH = 6,
  parameter int VGPR_ID_WIDTH    = 8,
  parameter int SGPR_ID_WIDTH    = 8,
  parameter int LDS_ID_WIDTH     = 8,
  parameter int GDS_ID_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WG_ID_WIDTH:0]      cfg_num_wg,
  input  logic [WG_SLOT_ID_WIDTH:0] cfg_num_wf,
  input  logic [5:0]                cfg_wf_size,
  input  logic [VGPR_ID_WIDTH:0]    cfg_vgpr_size_per_wf,
  input  logic [SGPR_ID_WIDTH:0]    cfg_sgpr_size_per_wf,
  input  logic [LDS_ID_WIDTH:0]     cfg_lds_size_total,
  input  logic [GDS_ID_WIDTH:0]     cfg_gds_size_total,
  host_wg_issuer_if.master          dis,
  output logic                      busy,
  output logic                      kernel_done,
  output logic                      cfg_error,
  output logic                      done_error,
  output logic [WG_ID_WIDTH:0]      wg_issued_count,
  output logic [WG_ID_WIDTH:0]      wg_done_count
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int VPROD_W = WG_SLOT_ID_WIDTH + VGPR_ID_WIDTH + 2;
  localparam int SPROD_W = WG_SLOT_ID_WIDTH + SGPR_ID_WIDTH + 2;

  logic [2:0]                state;
  logic [WG_ID_WIDTH:0]      num_wg_q;
  logic [WG_SLOT_ID_WIDTH:0] num_wf_q;
  logic [5:0]                wf_size_q;
  logic [VGPR_ID_WIDTH:0]    vgpr_pw_q, vgpr_tot_q;
  logic [SGPR_ID_WIDTH:0]    sgpr_pw_q, sgpr_tot_q;
  logic [LDS_ID_WIDTH:0]     lds_q;
  logic [GDS_ID_WIDTH:0]     gds_q;
  logic [(1<<WG_ID_WIDTH)-1:0] done_map;

  logic [VPROD_W-1:0] vgpr_prod;
  logic [SPROD_W-1:0] sgpr_prod;
  logic               launch_bad;
  logic               done_legal;

  // Full-width products; any bit above the field width means the total cannot be represented.
  assign vgpr_prod = VPROD_W'(num_wf_q) * VPROD_W'(vgpr_pw_q);
  assign sgpr_prod = SPROD_W'(num_wf_q) * SPROD_W'(sgpr_pw_q);

  // num_wg above 2^WG_ID_WIDTH: top bit set together with any lower bit.
  assign launch_bad = (num_wg_q == '0) || (num_wf_q == '0) ||
                      (num_wg_q[WG_ID_WIDTH] && (|num_wg_q[WG_ID_WIDTH-1:0])) ||
                      (|vgpr_prod[VPROD_W-1:VGPR_ID_WIDTH+1]) ||
                      (|sgpr_prod[SPROD_W-1:SGPR_ID_WIDTH+1]);

  // Ids below the issued count are always below num_wg, so this also covers out-of-range ids.
  assign done_legal = (state != S_IDLE) && (state != S_CHECK) &&
                      ({1'b0, dis.inflight_wg_buffer_host_wf_done_wg_id} < wg_issued_count) &&
                      !done_map[dis.inflight_wg_buffer_host_wf_done_wg_id];

  assign dis.host_wg_valid         = (state == S_ISSUE);
  assign dis.host_wg_id            = wg_issued_count[WG_ID_WIDTH-1:0];
  assign dis.host_num_wf           = num_wf_q;
  assign dis.host_wf_size          = wf_size_q;
  assign dis.host_vgpr_size_total  = vgpr_tot_q;
  assign dis.host_vgpr_size_per_wf = vgpr_pw_q;
  assign dis.host_sgpr_size_total  = sgpr_tot_q;
  assign dis.host_sgpr_size_per_wf = sgpr_pw_q;
  assign dis.host_lds_size_total   = lds_q;
  assign dis.host_gds_size_total   = gds_q;

  assign busy        = (state != S_IDLE);
  assign kernel_done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      num_wg_q        <= '0;
      num_wf_q        <= '0;
      wf_size_q       <= '0;
      vgpr_pw_q       <= '0;
      vgpr_tot_q      <= '0;
      sgpr_pw_q       <= '0;
      sgpr_tot_q      <= '0;
      lds_q           <= '0;
      gds_q           <= '0;
      done_map        <= '0;
      wg_issued_count <= '0;
      wg_done_count   <= '0;
      cfg_error       <= 1'b0;
      done_error      <= 1'b0;
    end else begin
      cfg_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            num_wg_q        <= cfg_num_wg;
            num_wf_q        <= cfg_num_wf;
            wf_size_q       <= cfg_wf_size;
            vgpr_pw_q       <= cfg_vgpr_size_per_wf;
            sgpr_pw_q       <= cfg_sgpr_size_per_wf;
            lds_q           <= cfg_lds_size_total;
            gds_q           <= cfg_gds_size_total;
            vgpr_tot_q      <= '0;
            sgpr_tot_q      <= '0;
            done_map        <= '0;
            wg_issued_count <= '0;
            wg_done_count   <= '0;
            done_error      <= 1'b0;
            state           <= S_CHECK;
          end
        end
        S_CHECK: begin
          // A reject holds CHECK one extra cycle so the error pulse precedes the return to IDLE.
          if (cfg_error) begin
            state <= S_IDLE;
          end else if (launch_bad) begin
            cfg_error <= 1'b1;
          end else begin
            vgpr_tot_q <= vgpr_prod[VGPR_ID_WIDTH:0];
            sgpr_tot_q <= sgpr_prod[SGPR_ID_WIDTH:0];
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (dis.inflight_wg_buffer_host_rcvd_ack) begin
            wg_issued_count <= wg_issued_count + (WG_ID_WIDTH+1)'(1);
            state           <= S_GAP;
          end
        end
        S_GAP: begin
          if (wg_issued_count < num_wg_q)       state <= S_ISSUE;
          else if (wg_done_count == num_wg_q)   state <= S_DONE;
          else                                  state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (wg_done_count == num_wg_q) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Completion tracking runs alongside the FSM in every state.
      if (dis.inflight_wg_buffer_host_wf_done) begin
        if (done_legal) begin
          done_map[dis.inflight_wg_buffer_host_wf_done_wg_id] <= 1'b1;
          wg_done_count <= wg_done_count + (WG_ID_WIDTH+1)'(1);
        end else begin
          done_error <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_host_wg_issuer.sv
// tb/tb_host_wg_issuer.sv - self-checking bench for host_wg_issuer
module tb_host_wg_issuer;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] cfg_num_wg;
  logic [6:0] cfg_num_wf;
  logic [5:0] cfg_wf_size;
  logic [8:0] cfg_vgpr_size_per_wf;
  logic [8:0] cfg_sgpr_size_per_wf;
  logic [8:0] cfg_lds_size_total;
  logic [8:0] cfg_gds_size_total;
  logic       busy, kernel_done, cfg_error, done_error;
  logic [6:0] wg_issued_count, wg_done_count;

  host_wg_issuer_if dis ();

  host_wg_issuer dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .cfg_num_wg           (cfg_num_wg),
    .cfg_num_wf           (cfg_num_wf),
    .cfg_wf_size          (cfg_wf_size),
    .cfg_vgpr_size_per_wf (cfg_vgpr_size_per_wf),
    .cfg_sgpr_size_per_wf (cfg_sgpr_size_per_wf),
    .cfg_lds_size_total   (cfg_lds_size_total),
    .cfg_gds_size_total   (cfg_gds_size_total),
    .dis                  (dis),
    .busy                 (busy),
    .kernel_done          (kernel_done),
    .cfg_error            (cfg_error),
    .done_error           (done_error),
    .wg_issued_count      (wg_issued_count),
    .wg_done_count        (wg_done_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: kernel phase plus issued/done bookkeeping, updated once per clock edge.
  // Phases: 0 idle, 1 validating, 2 reporting reject, 3 offering WG, 4 spacing, 5 waiting completions, 6 finished.
  int m_phase;
  int m_num_wg, m_num_wf, m_wf_size, m_vpw, m_spw, m_lds, m_gds, m_vtot, m_stot;
  int m_issued, m_done;
  bit m_err;
  bit m_bits [64];
  int m_old_issued, m_old_done, m_old_phase, m_id;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_issued = 0; m_done = 0; m_err = 0;
      m_num_wg = 0; m_num_wf = 0; m_wf_size = 0; m_vpw = 0; m_spw = 0;
      m_lds = 0; m_gds = 0; m_vtot = 0; m_stot = 0;
      foreach (m_bits[i]) m_bits[i] = 0;
    end else begin
      m_old_issued = m_issued;
      m_old_done   = m_done;
      m_old_phase  = m_phase;
      case (m_phase)
        0: if (start) begin
          m_num_wg = int'(cfg_num_wg);  m_num_wf = int'(cfg_num_wf);
          m_wf_size = int'(cfg_wf_size);
          m_vpw = int'(cfg_vgpr_size_per_wf); m_spw = int'(cfg_sgpr_size_per_wf);
          m_lds = int'(cfg_lds_size_total);   m_gds = int'(cfg_gds_size_total);
          m_vtot = 0; m_stot = 0; m_issued = 0; m_done = 0; m_err = 0;
          foreach (m_bits[i]) m_bits[i] = 0;
          m_phase = 1;
        end
        1: begin
          if (m_num_wg < 1 || m_num_wg > 64 || m_num_wf < 1 ||
              m_num_wf * m_vpw > 511 || m_num_wf * m_spw > 511) begin
            m_phase = 2;
          end else begin
            m_vtot = m_num_wf * m_vpw;
            m_stot = m_num_wf * m_spw;
            m_phase = 3;
          end
        end
        2: m_phase = 0;
        3: if (dis.inflight_wg_buffer_host_rcvd_ack) begin
          m_issued = m_issued + 1;
          m_phase = 4;
        end
        4: m_phase = (m_old_issued < m_num_wg) ? 3 : ((m_old_done == m_num_wg) ? 6 : 5);
        5: if (m_old_done == m_num_wg) m_phase = 6;
        6: m_phase = 0;
        default: m_phase = 0;
      endcase
      if (dis.inflight_wg_buffer_host_wf_done) begin
        m_id = int'(dis.inflight_wg_buffer_host_wf_done_wg_id);
        if (m_old_phase >= 3 && m_id < m_old_issued && !m_bits[m_id]) begin
          m_bits[m_id] = 1;
          m_done = m_done + 1;
        end else begin
          m_err = 1;
        end
      end
    end
  end

  int kd_cnt = 0, ce_cnt = 0, valid_cnt = 0;

  // Single compare process against the model, one step after every edge.
  always @(posedge clk) begin
    #1;
    chk("valid",       32'(dis.host_wg_valid), 32'(m_phase == 3));
    chk("busy",        32'(busy),              32'(m_phase != 0));
    chk("kernel_done", 32'(kernel_done),       32'(m_phase == 6));
    chk("cfg_error",   32'(cfg_error),         32'(m_phase == 2));
    chk("done_error",  32'(done_error),        32'(m_err));
    chk("issued_cnt",  32'(wg_issued_count),   m_issued);
    chk("done_cnt",    32'(wg_done_count),     m_done);
    if (m_phase == 3) begin
      chk("wg_id",     32'(dis.host_wg_id),            m_issued);
      chk("num_wf",    32'(dis.host_num_wf),           m_num_wf);
      chk("wf_size",   32'(dis.host_wf_size),          m_wf_size);
      chk("vgpr_tot",  32'(dis.host_vgpr_size_total),  m_vtot);
      chk("vgpr_pw",   32'(dis.host_vgpr_size_per_wf), m_vpw);
      chk("sgpr_tot",  32'(dis.host_sgpr_size_total),  m_stot);
      chk("sgpr_pw",   32'(dis.host_sgpr_size_per_wf), m_spw);
      chk("lds",       32'(dis.host_lds_size_total),   m_lds);
      chk("gds",       32'(dis.host_gds_size_total),   m_gds);
    end
    if (kernel_done)       kd_cnt++;
    if (cfg_error)         ce_cnt++;
    if (dis.host_wg_valid) valid_cnt++;
  end

  task automatic do_start(input int nwg, input int nwf, input int wfs, input int vpw,
                          input int spw, input int lds, input int gds);
    cfg_num_wg = 7'(nwg); cfg_num_wf = 7'(nwf); cfg_wf_size = 6'(wfs);
    cfg_vgpr_size_per_wf = 9'(vpw); cfg_sgpr_size_per_wf = 9'(spw);
    cfg_lds_size_total = 9'(lds);   cfg_gds_size_total = 9'(gds);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (dis.host_wg_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("valid_seen", 32'(dis.host_wg_valid), 32'd1);
  endtask

  task automatic issue_one(input int delay, output int id, output int vt, output int st);
    wait_valid();
    id = int'(dis.host_wg_id);
    vt = int'(dis.host_vgpr_size_total);
    st = int'(dis.host_sgpr_size_total);
    repeat (delay) @(negedge clk);
    dis.inflight_wg_buffer_host_rcvd_ack = 1'b1;
    @(negedge clk);
    dis.inflight_wg_buffer_host_rcvd_ack = 1'b0;
  endtask

  task automatic pulse_done(input int id);
    dis.inflight_wg_buffer_host_wf_done       = 1'b1;
    dis.inflight_wg_buffer_host_wf_done_wg_id = 6'(id);
    @(negedge clk);
    dis.inflight_wg_buffer_host_wf_done       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int ids [3];
    int vts [3];
    int sts [3];
    int kd0, ce0, vc0, d0, d1, d2;

    rst = 1'b1; start = 1'b0;
    cfg_num_wg = '0; cfg_num_wf = '0; cfg_wf_size = '0;
    cfg_vgpr_size_per_wf = '0; cfg_sgpr_size_per_wf = '0;
    cfg_lds_size_total = '0;   cfg_gds_size_total = '0;
    dis.inflight_wg_buffer_host_rcvd_ack      = 1'b0;
    dis.inflight_wg_buffer_host_wf_done       = 1'b0;
    dis.inflight_wg_buffer_host_wf_done_wg_id = '0;

    // 1: reset held three cycles
    repeat (3) @(negedge clk);
    chk("rst_valid",   32'(dis.host_wg_valid), 0);
    chk("rst_busy",    32'(busy), 0);
    chk("rst_vtot",    32'(dis.host_vgpr_size_total), 0);
    chk("rst_numwf",   32'(dis.host_num_wf), 0);
    chk("rst_lds",     32'(dis.host_lds_size_total), 0);
    chk("rst_counts",  32'({wg_issued_count, wg_done_count}), 0);
    chk("rst_flags",   32'({kernel_done, cfg_error, done_error}), 0);
    rst = 1'b0;
    @(negedge clk);

    // 2: three WGs, ack one cycle after valid, completions out of order
    kd0 = kd_cnt;
    do_start(3, 4, 32, 10, 5, 7, 3);
    chk("t2_busy_after_start", 32'(busy), 1);
    chk("t2_valid_in_check",   32'(dis.host_wg_valid), 0);
    @(negedge clk);
    chk("t2_issue_latency",    32'(dis.host_wg_valid), 1);
    for (int i = 0; i < 3; i++) issue_one(1, ids[i], vts[i], sts[i]);
    chk("t2_id0", ids[0], 0);
    chk("t2_id1", ids[1], 1);
    chk("t2_id2", ids[2], 2);
    chk("t2_vtot", vts[2], 40);
    chk("t2_stot", sts[0], 20);
    pulse_done(2);
    pulse_done(0);
    pulse_done(1);
    chk("t2_kdone_not_yet", 32'(kernel_done), 0);
    @(negedge clk);
    chk("t2_kdone_latency", 32'(kernel_done), 1);
    repeat (3) @(negedge clk);
    chk("t2_kdone_once", kd_cnt - kd0, 1);
    chk("t2_no_done_err", 32'(done_error), 0);
    chk("t2_idle", 32'(busy), 0);

    // 3: VGPR product 64*16 = 1024 does not fit in 9 bits
    ce0 = ce_cnt; vc0 = valid_cnt;
    do_start(1, 64, 16, 16, 1, 0, 0);
    @(negedge clk);
    chk("t3_cfg_error", 32'(cfg_error), 1);
    @(negedge clk);
    chk("t3_cfg_error_drop", 32'(cfg_error), 0);
    chk("t3_idle", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("t3_one_pulse", ce_cnt - ce0, 1);
    chk("t3_no_valid",  valid_cnt - vc0, 0);

    // 4: ack withheld 20 cycles, stray start ignored
    kd0 = kd_cnt;
    do_start(2, 3, 32, 7, 9, 100, 200);
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        cfg_num_wg = 7'd5; cfg_num_wf = 7'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("t4_still_valid", 32'(dis.host_wg_valid), 1);
    chk("t4_id_stable",   32'(dis.host_wg_id), 0);
    chk("t4_vtot_stable", 32'(dis.host_vgpr_size_total), 21);
    chk("t4_stot_stable", 32'(dis.host_sgpr_size_total), 27);
    chk("t4_lds_stable",  32'(dis.host_lds_size_total), 100);
    issue_one(0, d0, d1, d2);
    issue_one(0, d0, d1, d2);
    chk("t4_second_id", d0, 1);
    pulse_done(0);
    pulse_done(1);
    repeat (3) @(negedge clk);
    chk("t4_kdone", kd_cnt - kd0, 1);

    // 5: early and duplicate completions
    do_start(2, 1, 16, 1, 1, 1, 1);
    wait_valid();
    pulse_done(1);
    chk("t5_early_err",  32'(done_error), 1);
    chk("t5_early_cnt",  32'(wg_done_count), 0);
    issue_one(0, d0, d1, d2);
    pulse_done(0);
    chk("t5_legal_cnt",  32'(wg_done_count), 1);
    pulse_done(0);
    chk("t5_dup_err",    32'(done_error), 1);
    chk("t5_dup_cnt",    32'(wg_done_count), 1);
    issue_one(0, d0, d1, d2);
    pulse_done(1);
    repeat (3) @(negedge clk);
    chk("t5_finished", 32'(busy), 0);

    // 6: ack and completion on the same edge, then reset mid-issue
    do_start(2, 2, 8, 3, 3, 4, 4);
    chk("t6_err_cleared", 32'(done_error), 0);
    issue_one(0, d0, d1, d2);
    wait_valid();
    dis.inflight_wg_buffer_host_rcvd_ack      = 1'b1;
    dis.inflight_wg_buffer_host_wf_done       = 1'b1;
    dis.inflight_wg_buffer_host_wf_done_wg_id = 6'd0;
    @(negedge clk);
    dis.inflight_wg_buffer_host_rcvd_ack = 1'b0;
    dis.inflight_wg_buffer_host_wf_done  = 1'b0;
    chk("t6_issued_same_edge", 32'(wg_issued_count), 2);
    chk("t6_done_same_edge",   32'(wg_done_count), 1);
    pulse_done(1);
    repeat (3) @(negedge clk);
    do_start(3, 2, 8, 3, 3, 4, 4);
    wait_valid();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_valid",  32'(dis.host_wg_valid), 0);
    chk("t6_rst_busy",   32'(busy), 0);
    chk("t6_rst_issued", 32'(wg_issued_count), 0);
    chk("t6_rst_vtot",   32'(dis.host_vgpr_size_total), 0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
